// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction
// memory and registers the returned word into IF/ID with stall, redirect and halt.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] instructionAddress,
    input  logic [31:0] instruction,
    input  logic        stall,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    output logic [31:0] ifIdPc,
    output logic [31:0] ifIdInstruction,
    output logic        ifIdValid,
    output logic        halted,
    output logic [31:0] fetchCount
);

    localparam logic [0:0] RUN    = 1'b0;
    localparam logic [0:0] HALTED = 1'b1;

    logic [0:0]  state;
    logic [31:0] pc;

    assign instructionAddress = pc;
    // NOTE: halted is decoded from the state register, so it rises the cycle after the sentinel is seen.
    assign halted = (state == HALTED);

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= RUN;
            pc              <= RESET_PC;
            ifIdPc          <= 32'h0;
            ifIdInstruction <= NOP_WORD;
            ifIdValid       <= 1'b0;
            fetchCount      <= 32'h0;
        end else if (state == RUN) begin
            if (branchTaken) begin
                // Redirect wins over stall and over a wrong-path sentinel in the same cycle.
                pc              <= {branchTarget[31:2], 2'b00};
                ifIdPc          <= 32'h0;
                ifIdInstruction <= NOP_WORD;
                ifIdValid       <= 1'b0;
            end else if (!stall) begin
                if (instruction == HALT_WORD) begin
                    state           <= HALTED;
                    ifIdPc          <= 32'h0;
                    ifIdInstruction <= NOP_WORD;
                    ifIdValid       <= 1'b0;
                end else begin
                    pc              <= pc + 32'd4;
                    ifIdPc          <= pc;
                    ifIdInstruction <= instruction;
                    ifIdValid       <= 1'b1;
                    fetchCount      <= fetchCount + 32'd1;
                end
            end
        end
        // HALTED holds everything; IF/ID is already a bubble from the halt transition.
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run
// compared against a spec-level reference model of the fetch rules.
module tb_fetch_stage;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instructionAddress;
    logic [31:0] instruction;
    logic        stall = 1'b0;
    logic        branchTaken = 1'b0;
    logic [31:0] branchTarget = 32'h0;
    logic [31:0] ifIdPc;
    logic [31:0] ifIdInstruction;
    logic        ifIdValid;
    logic        halted;
    logic [31:0] fetchCount;

    // Memory: word = address ^ constant (never all-ones), unless a sentinel is planted.
    logic        halt_en = 1'b0;
    logic [31:0] halt_addr = 32'h0;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc, m_vpc, m_vins, m_cnt;
    logic        m_valid, m_halted;

    always #5 clk = ~clk;

    assign instruction = (halt_en && instructionAddress == halt_addr) ? HALT
                                                                      : (instructionAddress ^ 32'hA500_0001);

    fetch_stage dut (
        .clk                (clk),
        .reset              (reset),
        .instructionAddress (instructionAddress),
        .instruction        (instruction),
        .stall              (stall),
        .branchTaken        (branchTaken),
        .branchTarget       (branchTarget),
        .ifIdPc             (ifIdPc),
        .ifIdInstruction    (ifIdInstruction),
        .ifIdValid          (ifIdValid),
        .halted             (halted),
        .fetchCount         (fetchCount)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (halt_en && a == halt_addr) ? HALT : (a ^ 32'hA500_0001);
    endfunction

    // Drive one cycle of inputs, advance the model by the fetch rules, sample after the edge.
    task automatic step(input logic rst, input logic br, input logic [31:0] tgt, input logic st);
        logic [31:0] w;
        reset = rst; branchTaken = br; branchTarget = tgt; stall = st;
        w = mem_word(m_pc);
        if (rst) begin
            m_pc = 32'h0; m_vpc = 32'h0; m_vins = NOP; m_valid = 1'b0; m_halted = 1'b0; m_cnt = 32'h0;
        end else if (!m_halted) begin
            if (br) begin
                m_pc = tgt & ~32'h3; m_vpc = 32'h0; m_vins = NOP; m_valid = 1'b0;
            end else if (!st) begin
                if (w == HALT) begin
                    m_halted = 1'b1; m_vpc = 32'h0; m_vins = NOP; m_valid = 1'b0;
                end else begin
                    m_vpc = m_pc; m_vins = w; m_valid = 1'b1; m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h40, 1'b1);
        checks++; if (instructionAddress !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", instructionAddress, 32'h0); end
        checks++; if (ifIdPc !== 32'h0) begin errors++; $display("FAIL reset_ifidpc got %h want %h", ifIdPc, 32'h0); end
        checks++; if (ifIdInstruction !== NOP) begin errors++; $display("FAIL reset_ifidins got %h want %h", ifIdInstruction, NOP); end
        checks++; if (ifIdValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ifIdValid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
        checks++; if (fetchCount !== 32'h0) begin errors++; $display("FAIL reset_count got %0d want 0", fetchCount); end
    endtask

    task automatic test_free_run();
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            checks++; if (ifIdPc !== 32'(i * 4)) begin errors++; $display("FAIL run_ifidpc got %h want %h", ifIdPc, 32'(i * 4)); end
            checks++; if (ifIdValid !== 1'b1) begin errors++; $display("FAIL run_valid got %b want 1", ifIdValid); end
            checks++; if (ifIdInstruction !== mem_word(32'(i * 4))) begin errors++; $display("FAIL run_ins got %h want %h", ifIdInstruction, mem_word(32'(i * 4))); end
        end
        checks++; if (fetchCount !== 32'd2) begin errors++; $display("FAIL run_count got %0d want 2", fetchCount); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            checks++; if (instructionAddress !== 32'h8) begin errors++; $display("FAIL stall_pc got %h want %h", instructionAddress, 32'h8); end
            checks++; if (ifIdPc !== 32'h4 || ifIdInstruction !== mem_word(32'h4)) begin errors++; $display("FAIL stall_ifid got %h/%h want %h/%h", ifIdPc, ifIdInstruction, 32'h4, mem_word(32'h4)); end
            checks++; if (fetchCount !== 32'd2) begin errors++; $display("FAIL stall_count got %0d want 2", fetchCount); end
        end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (ifIdPc !== 32'h8 || ifIdInstruction !== mem_word(32'h8)) begin errors++; $display("FAIL release_ifid got %h/%h want %h/%h", ifIdPc, ifIdInstruction, 32'h8, mem_word(32'h8)); end
        checks++; if (fetchCount !== 32'd3) begin errors++; $display("FAIL release_count got %0d want 3", fetchCount); end
    endtask

    task automatic test_branch_over_stall();
        step(1'b0, 1'b1, 32'h23, 1'b1);
        checks++; if (instructionAddress !== 32'h20) begin errors++; $display("FAIL br_pc got %h want %h", instructionAddress, 32'h20); end
        checks++; if (ifIdValid !== 1'b0 || ifIdInstruction !== NOP || ifIdPc !== 32'h0) begin errors++; $display("FAIL br_bubble got %b/%h/%h want 0/%h/0", ifIdValid, ifIdInstruction, ifIdPc, NOP); end
        checks++; if (fetchCount !== 32'd3) begin errors++; $display("FAIL br_count got %0d want 3", fetchCount); end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (ifIdPc !== 32'h20 || ifIdValid !== 1'b1) begin errors++; $display("FAIL br_fetch got %h/%b want %h/1", ifIdPc, ifIdValid, 32'h20); end
    endtask

    task automatic test_halt();
        int n;
        halt_en = 1'b1; halt_addr = 32'h34;
        n = 0;
        while (!m_halted && n < 20) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            n++;
        end
        checks++; if (!m_halted) begin errors++; $display("FAIL halt_reach got pc %h want halt at %h", m_pc, 32'h34); end
        checks++; if (halted !== 1'b1 || instructionAddress !== 32'h34) begin errors++; $display("FAIL halt_state got %b/%h want 1/%h", halted, instructionAddress, 32'h34); end
        checks++; if (ifIdValid !== 1'b0 || ifIdInstruction !== NOP) begin errors++; $display("FAIL halt_bubble got %b/%h want 0/%h", ifIdValid, ifIdInstruction, NOP); end
        checks++; if (fetchCount !== 32'd8) begin errors++; $display("FAIL halt_count got %0d want 8", fetchCount); end
        step(1'b0, 1'b1, 32'h100, 1'b0);
        checks++; if (halted !== 1'b1 || instructionAddress !== 32'h34) begin errors++; $display("FAIL halt_ignore_br got %b/%h want 1/%h", halted, instructionAddress, 32'h34); end
        step(1'b1, 1'b0, 32'h0, 1'b0);
        checks++; if (halted !== 1'b0 || instructionAddress !== 32'h0) begin errors++; $display("FAIL halt_reset got %b/%h want 0/0", halted, instructionAddress); end
        halt_en = 1'b0;
    endtask

    task automatic test_halt_vs_branch();
        halt_en = 1'b1; halt_addr = 32'h0;
        step(1'b0, 1'b1, 32'h10, 1'b0);
        checks++; if (halted !== 1'b0 || instructionAddress !== 32'h10 || ifIdValid !== 1'b0) begin errors++; $display("FAIL halt_vs_br got %b/%h/%b want 0/%h/0", halted, instructionAddress, ifIdValid, 32'h10); end
        halt_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] tg [3];
        tg[0] = 32'h40; tg[1] = 32'h81; tg[2] = 32'h1236;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, tg[i], 1'b0);
            checks++; if (instructionAddress !== (tg[i] & ~32'h3) || ifIdValid !== 1'b0) begin errors++; $display("FAIL b2b_redirect got %h/%b want %h/0", instructionAddress, ifIdValid, tg[i] & ~32'h3); end
        end
        checks++; if (fetchCount !== m_cnt) begin errors++; $display("FAIL b2b_count got %0d want %0d", fetchCount, m_cnt); end
    endtask

    task automatic test_wrap();
        logic [31:0] cnt_before;
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        checks++; if (instructionAddress !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup got %h want %h", instructionAddress, 32'hFFFF_FFFC); end
        cnt_before = fetchCount;
        step(1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (instructionAddress !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h want 0", instructionAddress); end
        checks++; if (ifIdPc !== 32'hFFFF_FFFC || ifIdValid !== 1'b1) begin errors++; $display("FAIL wrap_ifid got %h/%b want %h/1", ifIdPc, ifIdValid, 32'hFFFF_FFFC); end
        checks++; if (fetchCount !== cnt_before + 32'd1) begin errors++; $display("FAIL wrap_count got %0d want %0d", fetchCount, cnt_before + 32'd1); end
    endtask

    task automatic test_random();
        logic        r, b, s;
        logic [31:0] t;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 39) == 0);
            b = ($urandom_range(0, 6) == 0);
            s = ($urandom_range(0, 3) == 0);
            t = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
            halt_en = ($urandom_range(0, 11) == 0);
            halt_addr = $urandom_range(0, 1) ? m_pc : 32'({$urandom_range(0, 63), 2'b00});
            step(r, b, t, s);
            checks++; if (instructionAddress !== m_pc) begin errors++; $display("FAIL rnd_pc cyc %0d got %h want %h", i, instructionAddress, m_pc); end
            checks++; if (ifIdPc !== m_vpc) begin errors++; $display("FAIL rnd_ifidpc cyc %0d got %h want %h", i, ifIdPc, m_vpc); end
            checks++; if (ifIdInstruction !== m_vins) begin errors++; $display("FAIL rnd_ins cyc %0d got %h want %h", i, ifIdInstruction, m_vins); end
            checks++; if (ifIdValid !== m_valid) begin errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", i, ifIdValid, m_valid); end
            checks++; if (halted !== m_halted) begin errors++; $display("FAIL rnd_halted cyc %0d got %b want %b", i, halted, m_halted); end
            checks++; if (fetchCount !== m_cnt) begin errors++; $display("FAIL rnd_count cyc %0d got %0d want %0d", i, fetchCount, m_cnt); end
        end
        halt_en = 1'b0;
    endtask

    initial begin
        m_pc = 32'h0; m_vpc = 32'h0; m_vins = NOP; m_cnt = 32'h0; m_valid = 1'b0; m_halted = 1'b0;
        test_reset();
        test_free_run();
        test_stall();
        test_branch_over_stall();
        test_halt();
        test_halt_vs_branch();
        test_back_to_back();
        test_wrap();
        step(1'b1, 1'b0, 32'h0, 1'b0);
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
